// File: rtl/byteen_data_mem.sv
// Byte-enabled data memory for the MIPS M-stage port: valid/ready requests, wait states, post-reset clear sweep.
// Optional commit trace is enabled by defining DM_TRACE_EN.
module byteen_data_mem #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        clr_done
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  clr_idx_q;
    logic [3:0]     cnt_q;
    logic [31:0]    lat_addr_q, lat_wdata_q;
    logic [3:0]     lat_be_q;

    logic           accept, load, commit, use_live, clr_last;
    logic [31:0]    c_addr, c_wdata, c_off, old_word;
    logic [3:0]     c_be;
    logic           c_oor;
    logic [AW-1:0]  c_idx;

    logic           mem_we;
    logic [AW-1:0]  mem_widx;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem [DEPTH_WORDS];

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] m;
        m = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

    assign accept   = req_valid && req_ready;
    assign clr_last = (clr_idx_q == AW'(DEPTH_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_CLEAR;
        else       state_q <= state_d;
    end

    // With zero wait states the accept edge is also the commit edge, so the live request is used directly.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        load      = 1'b0;
        commit    = 1'b0;
        use_live  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                if (clr_last) state_d = S_IDLE;
            end
            S_IDLE, S_RESP: begin
                req_ready = 1'b1;
                if (accept) begin
                    load = 1'b1;
                    if (LATENCY == 0) begin
                        state_d  = S_RESP;
                        commit   = 1'b1;
                        use_live = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                    end
                end else if (state_q == S_RESP) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        c_addr   = use_live ? req_addr   : lat_addr_q;
        c_wdata  = use_live ? req_wdata  : lat_wdata_q;
        c_be     = use_live ? req_byteen : lat_be_q;
        c_off    = c_addr - BASE_ADDR;
        c_oor    = ({1'b0, c_off} >= SPAN);
        c_idx    = c_off[AW+1:2];
        old_word = mem[c_idx];
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = c_idx;
        mem_wdata = lane_merge(old_word, c_wdata, c_be);
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                mem_we    = 1'b1;
                mem_widx  = clr_idx_q;
                mem_wdata = '0;
            end else if (commit && !c_oor && (c_be != 4'b0000)) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_idx_q <= '0;
            clr_done  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (state_q == S_CLEAR) begin
                clr_idx_q <= clr_idx_q + 1'b1;
                if (clr_last) clr_done <= 1'b1;
            end
            if (load)                   cnt_q <= 4'(LATENCY);
            else if (state_q == S_BUSY) cnt_q <= cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
            lat_be_q    <= req_byteen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= commit;
            if (commit) begin
                rsp_err   <= c_oor;
                rsp_rdata <= c_oor ? '0 : old_word;
            end
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] lat_pc_q, c_pc;

    always_ff @(posedge clk) begin
        if (load) lat_pc_q <= req_pc;
    end

    assign c_pc = use_live ? req_pc : lat_pc_q;

    always_ff @(posedge clk) begin
        if (!reset && commit && (c_be != 4'b0000)) begin
            if (c_oor) $display("%d@%h: *%h OOR", $time, c_pc, {c_addr[31:2], 2'b00});
            else       $display("%d@%h: *%h <= %h", $time, c_pc, {c_addr[31:2], 2'b00}, mem_wdata);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_byteen_data_mem.sv
// Scoreboard bench for byteen_data_mem: two instances (zero wait states at base 0, three wait states at base 0x1000).
module tb_byteen_data_mem;

    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_byteen [2];
    logic [31:0] req_pc     [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];
    logic        clr_done   [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [2][DEPTH];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    byteen_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000), .LATENCY(0)) u_dm0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_byteen(req_byteen[0]), .req_pc(req_pc[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .clr_done(clr_done[0])
    );

    byteen_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_1000), .LATENCY(3)) u_dm1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_byteen(req_byteen[1]), .req_pc(req_pc[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .clr_done(clr_done[1])
    );

    function automatic int unsigned lat_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'h0000_1000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: a word array; the response is the word before the write, out-of-range touches nothing.
    function automatic exp_t model_step(input int k, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be);
        exp_t        e;
        logic [31:0] off, old_w, new_w;
        int          idx;
        e.due = '0;
        off   = addr - base_of(k);
        if (off >= DEPTH * 4) begin
            e.rdata = '0;
            e.err   = 1'b1;
        end else begin
            idx   = int'(off / 4);
            old_w = model[k][idx];
            new_w = old_w;
            for (int i = 0; i < 4; i++)
                if (be[i]) new_w[8*i +: 8] = wdata[8*i +: 8];
            model[k][idx] = new_w;
            e.rdata = old_w;
            e.err   = 1'b0;
        end
        return e;
    endfunction

    task automatic issue(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int waits);
        exp_t e;
        req_valid[k]  = 1'b1;
        req_addr[k]   = addr;
        req_wdata[k]  = wdata;
        req_byteen[k] = be;
        req_pc[k]     = $urandom;
        waits = 0;
        while (!req_ready[k] && waits < 60) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready[k]) begin
            checks++;
            $display("FAIL accept_timeout dut%0d: req_ready got 0 after %0d cycles expected 1", k, waits);
            req_valid[k] = 1'b0;
            return;
        end
        e     = model_step(k, addr, wdata, be);
        e.due = cyc + 1 + lat_of(k);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int k, input int n);
        req_valid[k] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic mon(input int k);
        exp_t e;
        if (!rsp_valid[k]) return;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            checks++;
            $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected no response", k);
            return;
        end
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("rdata%0d", k), rsp_rdata[k], e.rdata);
        check($sformatf("err%0d", k), 32'(rsp_err[k]), 32'(e.err));
        check($sformatf("rsp_cycle%0d", k), cyc, e.due);
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic wait_sweep();
        int   n   = 0;
        logic bad = 1'b0;
        while (!clr_done[0] && n < 100) begin
            @(negedge clk);
            n++;
            if (!clr_done[0] && (req_ready[0] || req_ready[1])) bad = 1'b1;
        end
        check("sweep_cycles", n, DEPTH);
        check("ready_low_in_clear", 32'(bad), 0);
        check("clr_done_dut1", 32'(clr_done[1]), 1);
        check("ready_after_clear", 32'(req_ready[0]), 1);
    endtask

    // One reset edge; any in-flight request is forgotten by both the DUT and the model.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) model[k][i] = '0;
            check($sformatf("rst_ready%0d", k), 32'(req_ready[k]), 0);
            check($sformatf("rst_rsp_valid%0d", k), 32'(rsp_valid[k]), 0);
            check($sformatf("rst_rdata%0d", k), rsp_rdata[k], 0);
            check($sformatf("rst_err%0d", k), 32'(rsp_err[k]), 0);
            check($sformatf("rst_clr_done%0d", k), 32'(clr_done[k]), 0);
        end
        reset = 1'b0;
        wait_sweep();
    endtask

    task automatic rand_traffic(input int k, input int n);
        logic [31:0] addr;
        logic [3:0]  be;
        int          w;
        for (int i = 0; i < n; i++) begin
            addr = base_of(k) + 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = base_of(k) - 32'($urandom_range(1, 8));
            be = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            issue(k, addr, $urandom, be, w);
            if ($urandom_range(0, 3) == 0) idle(k, int'($urandom_range(1, 3)));
        end
        idle(k, 6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k]  = 1'b0;
            req_addr[k]   = '0;
            req_wdata[k]  = '0;
            req_byteen[k] = '0;
            req_pc[k]     = '0;
        end
        repeat (2) @(negedge clk);
        do_reset();

        issue(0, 32'h0000_0008, 32'h1234_5678, 4'hF, w);
        issue(0, 32'h0000_0008, 32'h0, 4'h0, w);
        check("b2b_wait_lat0", w, 0);
        issue(0, 32'h0000_000A, 32'hAABB_CCDD, 4'b0101, w);
        issue(0, 32'h0000_0008, 32'h0, 4'h0, w);
        issue(0, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, w);
        issue(0, 32'h0000_0000, 32'h0, 4'h0, w);
        idle(0, 3);

        issue(1, 32'h0000_0FFC, 32'h0, 4'h0, w);
        idle(1, 1);
        issue(1, 32'h0000_1008, 32'hCAFE_F00D, 4'hF, w);
        issue(1, 32'h0000_1008, 32'h0, 4'h0, w);
        check("b2b_wait_lat3", w, 3);
        issue(1, 32'h0000_1040, 32'h5555_AAAA, 4'hF, w);
        issue(1, 32'h0000_1000, 32'h0, 4'h0, w);
        idle(1, 6);

        fork
            rand_traffic(0, 150);
            rand_traffic(1, 150);
        join

        issue(1, 32'h0000_1004, 32'h1111_2222, 4'hF, w);
        idle(1, 5);
        issue(1, 32'h0000_1004, 32'h3333_4444, 4'hF, w);
        req_valid[1] = 1'b0;
        do_reset();
        issue(1, 32'h0000_1004, 32'h0, 4'h0, w);
        idle(1, 6);
        idle(0, 2);

        check("queues_drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
